// File: rtl/serv_rf_arb.sv
// Round-robin arbiter sharing one register-file RAM among N_HARTS cores; grant registered, one cycle after request.
// Define SERV_RF_ARB_WDOG_EN to bound each burst to MAX_BURST grant cycles with an o_wdog expiry pulse.
module serv_rf_arb #(
  parameter int N_HARTS   = 2,
  parameter int RF_WIDTH  = 2,
  parameter int RF_L2D    = 10,
  parameter int MAX_BURST = 64
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [N_HARTS-1:0]           i_req,
  output logic [N_HARTS-1:0]           o_gnt,
  input  logic [N_HARTS-1:0]           i_ren,
  input  logic [N_HARTS-1:0]           i_wen,
  input  logic [N_HARTS*RF_L2D-1:0]    i_raddr,
  input  logic [N_HARTS*RF_L2D-1:0]    i_waddr,
  input  logic [N_HARTS*RF_WIDTH-1:0]  i_wdata,
  output logic                         o_ren,
  output logic                         o_wen,
  output logic [RF_L2D-1:0]            o_raddr,
  output logic [RF_L2D-1:0]            o_waddr,
  output logic [RF_WIDTH-1:0]          o_wdata,
  input  logic [RF_WIDTH-1:0]          i_rdata,
  output logic [RF_WIDTH-1:0]          o_rdata,
  output logic [N_HARTS-1:0]           o_rvalid
`ifdef SERV_RF_ARB_WDOG_EN
  ,
  output logic                         o_wdog
`endif
);

  localparam int IW = $clog2(N_HARTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [IW-1:0]       gidx, gidx_nxt;
  logic [N_HARTS-1:0]  gnt_nxt;
  logic [N_HARTS-1:0]  elig;
  logic [IW-1:0]       sel;
  logic                found;
  logic                active;
  int                  rr_pos;
  logic [IW-1:0]       rr_cand;

`ifdef SERV_RF_ARB_WDOG_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0]       cnt, cnt_nxt;
  logic [N_HARTS-1:0]  blocked;
  logic                expire;

  // A hart cut off by the watchdog stays out of arbitration until it drops its request.
  assign elig = i_req & ~blocked;
`else
  assign elig = i_req;
`endif

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    rr_pos  = 0;
    rr_cand = '0;
    for (int i = 0; i < N_HARTS; i++) begin
      rr_pos = int'(ptr) + i;
      if (rr_pos >= N_HARTS) rr_pos = rr_pos - N_HARTS;
      rr_cand = IW'(rr_pos);
      if (!found && elig[rr_cand]) begin
        found = 1'b1;
        sel   = rr_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_gnt    <= '0;
      gidx     <= '0;
      ptr      <= '0;
      o_rvalid <= '0;
`ifdef SERV_RF_ARB_WDOG_EN
      cnt      <= '0;
      blocked  <= '0;
      o_wdog   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      o_gnt    <= gnt_nxt;
      gidx     <= gidx_nxt;
      ptr      <= ptr_nxt;
      o_rvalid <= {N_HARTS{o_ren}} & o_gnt;
`ifdef SERV_RF_ARB_WDOG_EN
      cnt      <= cnt_nxt;
      blocked  <= (blocked & i_req) | (expire ? o_gnt : '0);
      o_wdog   <= expire;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = o_gnt;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
`ifdef SERV_RF_ARB_WDOG_EN
    cnt_nxt   = cnt;
    expire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          gnt_nxt      = '0;
          gnt_nxt[sel] = 1'b1;
          gidx_nxt     = sel;
          ptr_nxt      = (sel == IW'(N_HARTS - 1)) ? '0 : sel + 1'b1;
`ifdef SERV_RF_ARB_WDOG_EN
          cnt_nxt      = CW'(1);
`endif
        end
      end
      GRANT: begin
        if (!i_req[gidx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
`ifdef SERV_RF_ARB_WDOG_EN
          cnt_nxt   = '0;
        end else if (cnt == CW'(MAX_BURST)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          expire    = 1'b1;
        end else begin
          cnt_nxt   = cnt + 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Enables are gated so a non-granted hart or a reset cycle can never touch the RAM.
  always_comb begin
    active  = (|o_gnt) && !i_rst;
    o_ren   = active && i_ren[gidx];
    o_wen   = active && i_wen[gidx];
    o_raddr = i_raddr[int'(gidx)*RF_L2D +: RF_L2D];
    o_waddr = i_waddr[int'(gidx)*RF_L2D +: RF_L2D];
    o_wdata = i_wdata[int'(gidx)*RF_WIDTH +: RF_WIDTH];
  end

  assign o_rdata = i_rdata;

endmodule

// File: tb/tb_serv_rf_arb.sv
// Bench for serv_rf_arb: directed vector table, hand-written contention/burst-limit sequences, random run against a reference model.
module tb_serv_rf_arb;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int L2D = 10;
  localparam int MB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, ren, wen;
  logic [N*L2D-1:0] raddr, waddr;
  logic [N*W-1:0]   wdata;
  logic [W-1:0]     rdata_in;
  logic [N-1:0]     gnt, rvalid;
  logic             o_ren, o_wen;
  logic [L2D-1:0]   o_raddr, o_waddr;
  logic [W-1:0]     o_wdata, o_rdata;
`ifdef SERV_RF_ARB_WDOG_EN
  logic             wdog;
`endif

  serv_rf_arb #(.N_HARTS(N), .RF_WIDTH(W), .RF_L2D(L2D), .MAX_BURST(MB)) dut (
    .clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt),
    .i_ren(ren), .i_wen(wen), .i_raddr(raddr), .i_waddr(waddr), .i_wdata(wdata),
    .o_ren(o_ren), .o_wen(o_wen), .o_raddr(o_raddr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_rdata(rdata_in), .o_rdata(o_rdata), .o_rvalid(rvalid)
`ifdef SERV_RF_ARB_WDOG_EN
    , .o_wdog(wdog)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int h);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return (h < 0) ? '0 : (one << h);
  endfunction

  typedef struct {
    logic         rst;
    logic [N-1:0] req, ren, wen;
    logic [N-1:0] e_gnt;
    logic         e_ren, e_wen;
    logic [N-1:0] e_rv;
    logic [L2D-1:0] e_raddr;
  } vec_t;

  vec_t tbl [13];

  // Reference model: granted hart (-1 = none), round-robin start, burst length, pending read-valid.
  int           mg, mptr, mcnt;
  logic [N-1:0] mrv, mblk;
  logic         mwd;

  task automatic model_edge();
    logic [N-1:0] el;
    if (rst) begin
      mg = -1; mptr = 0; mcnt = 0; mrv = '0; mblk = '0; mwd = 1'b0;
      return;
    end
    mrv = (mg >= 0 && ren[mg]) ? onehot(mg) : '0;
    mwd = 1'b0;
    el  = req & ~mblk;
    mblk = mblk & req;
    if (mg < 0) begin
      for (int i = 0; i < N; i++) begin
        int h;
        h = (mptr + i) % N;
        if (el[h]) begin
          mg = h; mptr = (h + 1) % N; mcnt = 1;
          break;
        end
      end
    end else if (!req[mg]) begin
      mg = -1;
    end else begin
`ifdef SERV_RF_ARB_WDOG_EN
      if (mcnt == MB) begin
        mblk[mg] = 1'b1; mwd = 1'b1; mg = -1;
      end else
`endif
      mcnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 10'h000};
    tbl[1]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 10'h000};
    tbl[2]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 10'h012};
    tbl[3]  = '{1'b0, 4'h1, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, 4'h1, 10'h012};
    tbl[4]  = '{1'b0, 4'h3, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, 4'h0, 10'h012};
    tbl[5]  = '{1'b0, 4'h3, 4'h1, 4'h2, 4'h1, 1'b1, 1'b0, 4'h0, 10'h012};
    tbl[6]  = '{1'b0, 4'h2, 4'h1, 4'h2, 4'h1, 1'b1, 1'b0, 4'h1, 10'h012};
    tbl[7]  = '{1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h1, 10'h000};
    tbl[8]  = '{1'b0, 4'h2, 4'h0, 4'h2, 4'h2, 1'b0, 1'b1, 4'h0, 10'h022};
    tbl[9]  = '{1'b1, 4'h2, 4'h0, 4'h2, 4'h2, 1'b0, 1'b0, 4'h0, 10'h022};
    tbl[10] = '{1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 10'h000};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 4'h0, 10'h022};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 10'h000};

    mg = -1; mptr = 0; mcnt = 0; mrv = '0; mblk = '0; mwd = 1'b0;
    rst = 1'b1; req = '0; ren = '0; wen = '0; rdata_in = '0;
    raddr = {10'h042, 10'h032, 10'h022, 10'h012};
    waddr = {10'h043, 10'h033, 10'h023, 10'h013};
    wdata = 8'b11_10_01_00;
    cyc(); cyc();

    // Directed vector table: single request, isolation, tail read, reset mid-burst.
    for (int k = 0; k < 13; k++) begin
      cyc();
      rst = tbl[k].rst; req = tbl[k].req; ren = tbl[k].ren; wen = tbl[k].wen;
      @(negedge clk);
      chk($sformatf("tbl%0d gnt", k), 32'(gnt), 32'(tbl[k].e_gnt));
      chk($sformatf("tbl%0d ren", k), 32'(o_ren), 32'(tbl[k].e_ren));
      chk($sformatf("tbl%0d wen", k), 32'(o_wen), 32'(tbl[k].e_wen));
      chk($sformatf("tbl%0d rvalid", k), 32'(rvalid), 32'(tbl[k].e_rv));
      if (tbl[k].e_gnt != '0)
        chk($sformatf("tbl%0d raddr", k), 32'(o_raddr), 32'(tbl[k].e_raddr));
    end

    // Contention: all harts requesting, each drops in its third grant cycle.
    cyc(); rst = 1'b1; req = '0; ren = '0; wen = '0;
    for (int b = 0; b < 5; b++) begin
      cyc(); rst = 1'b0; req = 4'hF;
      @(negedge clk);
      chk($sformatf("rr burst%0d idle gnt", b), 32'(gnt), 32'h0);
      for (int k = 1; k <= 3; k++) begin
        cyc();
        req = (k == 3) ? ~onehot(b % N) : 4'hF;
        @(negedge clk);
        chk($sformatf("rr burst%0d cyc%0d gnt", b, k), 32'(gnt), 32'(onehot(b % N)));
      end
    end

    // Long burst from hart 0: bounded by the watchdog when enabled, unbounded otherwise.
    cyc(); rst = 1'b1; req = '0;
`ifdef SERV_RF_ARB_WDOG_EN
    for (int c = 0; c < 24; c++) begin
      cyc(); rst = 1'b0;
      req = (c == 20 || c == 23) ? 4'h0 : 4'h1;
      @(negedge clk);
      chk($sformatf("wdog c%0d gnt", c), 32'(gnt),
          ((c >= 1 && c <= 8) || c >= 22) ? 32'h1 : 32'h0);
      chk($sformatf("wdog c%0d pulse", c), 32'(wdog), (c == 9) ? 32'h1 : 32'h0);
    end
`else
    for (int c = 0; c < 22; c++) begin
      cyc(); rst = 1'b0;
      req = (c < 20) ? 4'h1 : 4'h0;
      @(negedge clk);
      chk($sformatf("long c%0d gnt", c), 32'(gnt), (c >= 1 && c <= 20) ? 32'h1 : 32'h0);
    end
`endif

    // Randomised run against the reference model.
    cyc(); rst = 1'b1; req = '0; ren = '0; wen = '0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      model_edge();
      #1;
      rst = ($urandom_range(0, 99) == 0);
      for (int h = 0; h < N; h++) begin
        if (req[h]) begin
          if ($urandom_range(0, 5) == 0) req[h] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[h] = 1'b1;
        end
        raddr[h*L2D +: L2D] = L2D'($urandom);
        waddr[h*L2D +: L2D] = L2D'($urandom);
        wdata[h*W +: W]     = W'($urandom);
      end
      ren = N'($urandom);
      wen = N'($urandom);
      rdata_in = W'($urandom);
      @(negedge clk);
      chk("rnd gnt", 32'(gnt), 32'(onehot(mg)));
      chk("rnd ren", 32'(o_ren), (mg >= 0 && !rst) ? 32'(ren[mg]) : 32'h0);
      chk("rnd wen", 32'(o_wen), (mg >= 0 && !rst) ? 32'(wen[mg]) : 32'h0);
      chk("rnd rvalid", 32'(rvalid), 32'(mrv));
      chk("rnd rdata", 32'(o_rdata), 32'(rdata_in));
      if (mg >= 0) begin
        chk("rnd raddr", 32'(o_raddr), 32'(raddr[mg*L2D +: L2D]));
        chk("rnd waddr", 32'(o_waddr), 32'(waddr[mg*L2D +: L2D]));
        chk("rnd wdata", 32'(o_wdata), 32'(wdata[mg*W +: W]));
      end
`ifdef SERV_RF_ARB_WDOG_EN
      chk("rnd wdog", 32'(wdog), 32'(mwd));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
